// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control sequencer: Moore decode of state (branch pc_write also depends on the flags), 3-5 cycles per instruction.
// `define MC_MEM_WAIT_EN adds mem_ready; FETCH/MEM_RD/MEM_WR stall while it is low.
module mc_control_fsm #(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
`ifdef MC_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       blt,
    input  logic       bge,
    input  logic       bltu,
    input  logic       bgeu,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_addr_sel,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [2:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] hold_cnt;
    logic       illegal_q;
    logic       mem_rdy;
    logic       br_taken;
    logic       br_bad;

`ifdef MC_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    assign state   = cur_state;
    assign illegal = illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_RESET;
            hold_cnt  <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (nxt_state == S_TRAP)
                illegal_q <= 1'b1;
            if (cur_state == S_RESET)
                hold_cnt <= hold_cnt + 4'd1;
        end
    end

    // funct3 010/011 are not branch encodings and send the core to TRAP.
    always_comb begin
        br_taken = 1'b0;
        br_bad   = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = blt;
            3'b101:  br_taken = bge;
            3'b110:  br_taken = bltu;
            3'b111:  br_taken = bgeu;
            default: br_bad   = 1'b1;
        endcase
    end

    always_comb begin
        nxt_state    = cur_state;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        ir_write     = 1'b0;
        mem_addr_sel = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 3'd0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        alu_op       = 2'b00;
        instr_done   = 1'b0;
        case (cur_state)
            S_RESET: begin
                if (hold_cnt >= HOLD_LAST)
                    nxt_state = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_rdy;
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                pc_write  = mem_rdy;
                if (mem_rdy)
                    nxt_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'd1;
                case (opcode)
                    7'b0110011: nxt_state = S_EXEC_R;
                    7'b0010011: nxt_state = S_EXEC_I;
                    7'b0000011,
                    7'b0100011: nxt_state = S_MEM_ADDR;
                    7'b1100011: nxt_state = S_BRANCH;
                    7'b1101111: nxt_state = S_JAL;
                    7'b1100111: nxt_state = S_JALR;
                    7'b0110111: nxt_state = S_LUI;
                    7'b0010111: nxt_state = S_AUIPC;
                    default:    nxt_state = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'd1;
                alu_op    = 2'b10;
                nxt_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_op    = 2'b11;
                nxt_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                wb_sel     = 3'd4;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                nxt_state = opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read     = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_rdy)
                    nxt_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write    = 1'b1;
                mem_addr_sel = 1'b1;
                instr_done   = mem_rdy;
                if (mem_rdy)
                    nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'd1;
                alu_op     = 2'b01;
                pc_src     = 2'd1;
                pc_write   = br_taken;
                instr_done = !br_bad;
                nxt_state  = br_bad ? S_TRAP : S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_src     = 2'd1;
                reg_write  = 1'b1;
                wb_sel     = 3'd3;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd1;
                pc_write   = 1'b1;
                pc_src     = 2'd2;
                reg_write  = 1'b1;
                wb_sel     = 3'd3;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_LUI: begin
                reg_write  = 1'b1;
                wb_sel     = 3'd2;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_AUIPC: begin
                reg_write  = 1'b1;
                wb_sel     = 3'd4;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_TRAP: begin
                nxt_state = S_TRAP;
            end
            default: begin
                nxt_state = S_TRAP;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios plus random instruction streams
// checked against a path/output model built from the instruction classes.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero, blt, bge, bltu, bgeu;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write, mem_addr_sel, mem_read, mem_write, reg_write;
    logic [2:0] wb_sel;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       instr_done, illegal;
    logic [3:0] state;
`ifdef MC_MEM_WAIT_EN
    logic       mem_ready;
`endif

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_addr_sel;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [2:0] wb_sel;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    outs_t act;
    assign act = {pc_write, pc_src, ir_write, mem_addr_sel, mem_read, mem_write,
                  reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, instr_done, illegal};

    int checks = 0;
    int errors = 0;
    int path_q[$];

    always #5 clk = ~clk;

    mc_control_fsm #(.RESET_PC_HOLD(1)) dut (
        .clk(clk), .rst(rst),
`ifdef MC_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .opcode(opcode), .funct3(funct3),
        .zero(zero), .blt(blt), .bge(bge), .bltu(bltu), .bgeu(bgeu),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_addr_sel(mem_addr_sel), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    // Expected control word for a given state, written straight from the state tables.
    function automatic outs_t spec_out(input int st, input bit taken, input bit bad_br);
        outs_t o = '0;
        case (st)
            1:  begin o.mem_read = 1; o.ir_write = 1; o.a = 2; o.b = 2; o.pc_write = 1; end
            2:  begin o.b = 1; end
            3:  begin o.a = 1; o.op = 2; end
            4:  begin o.a = 1; o.b = 1; o.op = 3; end
            5:  begin o.reg_write = 1; o.wb_sel = 4; o.instr_done = 1; end
            6:  begin o.a = 1; o.b = 1; end
            7:  begin o.mem_read = 1; o.mem_addr_sel = 1; end
            8:  begin o.reg_write = 1; o.wb_sel = 0; o.instr_done = 1; end
            9:  begin o.mem_write = 1; o.mem_addr_sel = 1; o.instr_done = 1; end
            10: begin o.a = 1; o.op = 1; o.pc_src = 1; o.pc_write = taken && !bad_br; o.instr_done = !bad_br; end
            11: begin o.pc_write = 1; o.pc_src = 1; o.reg_write = 1; o.wb_sel = 3; o.instr_done = 1; end
            12: begin o.a = 1; o.b = 1; o.pc_write = 1; o.pc_src = 2; o.reg_write = 1; o.wb_sel = 3; o.instr_done = 1; end
            13: begin o.reg_write = 1; o.wb_sel = 2; o.instr_done = 1; end
            14: begin o.reg_write = 1; o.wb_sel = 4; o.instr_done = 1; end
            15: begin o.illegal = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Branch outcome from the operand values themselves, not from the flags.
    function automatic bit model_taken(input logic [2:0] f3, input logic [31:0] va, input logic [31:0] vb);
        case (f3)
            3'b000:  return va == vb;
            3'b001:  return va != vb;
            3'b100:  return $signed(va) <  $signed(vb);
            3'b101:  return $signed(va) >= $signed(vb);
            3'b110:  return va <  vb;
            3'b111:  return va >= vb;
            default: return 1'b0;
        endcase
    endfunction

    task automatic build_path(input logic [6:0] opc, input logic [2:0] f3);
        path_q = {};
        case (opc)
            7'b0110011: path_q = {1, 2, 3, 5};
            7'b0010011: path_q = {1, 2, 4, 5};
            7'b0000011: path_q = {1, 2, 6, 7, 8};
            7'b0100011: path_q = {1, 2, 6, 9};
            7'b1100011: path_q = (f3 == 3'b010 || f3 == 3'b011) ? '{1, 2, 10, 15} : '{1, 2, 10};
            7'b1101111: path_q = {1, 2, 11};
            7'b1100111: path_q = {1, 2, 12};
            7'b0110111: path_q = {1, 2, 13};
            7'b0010111: path_q = {1, 2, 14};
            default:    path_q = {1, 2, 15};
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_to_fetch();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20 && state !== 4'd1; i++)
            tick();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL reset_to_fetch: state %0d, expected 1", state);
        end
    endtask

    // Runs one instruction from FETCH; leaves the DUT in FETCH or TRAP.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3,
                             input logic [31:0] va, input logic [31:0] vb, input string name);
        bit    taken, bad_br, ended_trap;
        outs_t exp;
        opcode = opc;
        funct3 = f3;
        zero   = (va == vb);
        blt    = $signed(va) < $signed(vb);
        bge    = !blt;
        bltu   = va < vb;
        bgeu   = !bltu;
        taken  = model_taken(f3, va, vb);
        bad_br = (f3 == 3'b010 || f3 == 3'b011);
        build_path(opc, f3);
        ended_trap = (path_q[path_q.size()-1] == 15);
        for (int i = 0; i < path_q.size(); i++) begin
            exp = spec_out(path_q[i], taken, bad_br);
            checks++;
            if (state !== 4'(path_q[i])) begin
                errors++;
                $display("FAIL %s cycle %0d state: got %0d expected %0d", name, i, state, path_q[i]);
                reset_to_fetch();
                return;
            end
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d outputs (state %0d): got %h expected %h", name, i, state, act, exp);
            end
            if (!ended_trap || i < path_q.size() - 1)
                tick();
        end
        checks++;
        if (state !== (ended_trap ? 4'd15 : 4'd1)) begin
            errors++;
            $display("FAIL %s end state: got %0d expected %0d", name, state, ended_trap ? 15 : 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (state !== 4'd0 || act !== '0) begin
            errors++;
            $display("FAIL reset_hold1: state %0d outs %h, expected 0/0", state, act);
        end
        tick();
        checks++;
        if (state !== 4'd0 || act !== '0) begin
            errors++;
            $display("FAIL reset_hold2: state %0d outs %h, expected 0/0", state, act);
        end
        rst = 1'b0;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL reset_first_free_cycle: state %0d, expected 0", state);
        end
        tick();
        checks++;
        if (state !== 4'd1 || pc_write !== 1'b1 || ir_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_to_fetch_edge: state %0d pc_write %b ir_write %b, expected 1/1/1",
                     state, pc_write, ir_write);
        end
    endtask

    task automatic test_alu_mem();
        run_instr(7'b0110011, 3'b000, 32'd5, 32'd7, "r_type");
        run_instr(7'b0010011, 3'b111, 32'd1, 32'd2, "i_type");
        run_instr(7'b0000011, 3'b010, 32'd0, 32'd0, "load");
        run_instr(7'b0100011, 3'b010, 32'd0, 32'd0, "store");
    endtask

    task automatic test_branch();
        run_instr(7'b1100011, 3'b001, 32'd9, 32'd9, "bne_equal");
        run_instr(7'b1100011, 3'b110, 32'd1, 32'hFFFF_FFFF, "bltu_taken");
        run_instr(7'b1100011, 3'b100, 32'hFFFF_FFFF, 32'd1, "blt_signed");
    endtask

    task automatic test_jumps();
        run_instr(7'b1100111, 3'b000, 32'd0, 32'd0, "jalr");
        run_instr(7'b1101111, 3'b000, 32'd0, 32'd0, "jal");
        run_instr(7'b0110111, 3'b000, 32'd0, 32'd0, "lui");
        run_instr(7'b0010111, 3'b000, 32'd0, 32'd0, "auipc");
        run_instr(7'b0000000, 3'b000, 32'd0, 32'd0, "opcode_zero");
        reset_to_fetch();
    endtask

    task automatic test_trap_sticky();
        run_instr(7'b1100011, 3'b010, 32'd3, 32'd4, "branch_f3_010");
        for (int i = 0; i < 10; i++) begin
            opcode = 7'($urandom);
            funct3 = 3'($urandom);
            tick();
            checks++;
            if (state !== 4'd15 || illegal !== 1'b1 || mem_read !== 1'b0 ||
                mem_write !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0) begin
                errors++;
                $display("FAIL trap_sticky cycle %0d: state %0d illegal %b outs %h", i, state, illegal, act);
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL trap_rst_clear: state %0d illegal %b, expected 0/0", state, illegal);
        end
        reset_to_fetch();
    endtask

    task automatic test_mid_reset();
        opcode = 7'b0000011;
        funct3 = 3'b010;
        tick();
        tick();
        tick();
        checks++;
        if (state !== 4'd7) begin
            errors++;
            $display("FAIL mid_reset_setup: state %0d, expected 7", state);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (state !== 4'd0 || act !== '0) begin
            errors++;
            $display("FAIL mid_reset_abandon: state %0d outs %h, expected 0/0", state, act);
        end
        reset_to_fetch();
    endtask

    task automatic test_random();
        logic [6:0]  legal [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] va, vb;
        int          k;
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 10);
            if (k < 9) opc = legal[k];
            else if (k == 9) opc = 7'b1100011;
            else begin
                opc = 7'($urandom);
                for (int j = 0; j < 9; j++)
                    if (opc == legal[j]) opc = 7'b1111111;
            end
            f3 = 3'($urandom);
            va = $urandom;
            vb = ($urandom_range(0, 3) == 0) ? va : $urandom;
            run_instr(opc, f3, va, vb, "random");
            if (state === 4'd15)
                reset_to_fetch();
        end
    endtask

`ifdef MC_MEM_WAIT_EN
    task automatic test_mem_wait();
        opcode = 7'b0000011;
        funct3 = 3'b010;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 4'd1 || mem_read !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
                errors++;
                $display("FAIL fetch_wait cycle %0d: state %0d mem_read %b ir_write %b", i, state, mem_read, ir_write);
            end
            tick();
        end
        mem_ready = 1'b1;
        checks++;
        if (state !== 4'd1 || ir_write !== 1'b1) begin
            errors++;
            $display("FAIL fetch_ready: state %0d ir_write %b, expected 1/1", state, ir_write);
        end
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        checks++;
        if (state !== 4'd7 || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL memrd_wait: state %0d mem_read %b, expected 7/1", state, mem_read);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL memrd_wait_rst: state %0d, expected 0", state);
        end
        mem_ready = 1'b1;
        reset_to_fetch();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        opcode = 7'd0;
        funct3 = 3'd0;
        zero = 0; blt = 0; bge = 0; bltu = 0; bgeu = 0;
`ifdef MC_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        test_reset();
        test_alu_mem();
        test_branch();
        test_jumps();
        test_trap_sticky();
        test_mid_reset();
`ifdef MC_MEM_WAIT_EN
        test_mem_wait();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
